// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// hex glyph table, digit count and the per-frame content record.
package sseg_pkg;

   localparam int NUM_DIGITS = 4;

   // Bit positions inside the 8-bit sseg output (a is the MSB, dp the LSB).
   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   // Glyphs as {a,b,c,d,e,f,g}, indexed by hex code.
   localparam logic [6:0] GLYPH_ROM [16] = '{
      7'b1111110,  // 0
      7'b0110000,  // 1
      7'b1101101,  // 2
      7'b1111001,  // 3
      7'b0110011,  // 4
      7'b1011011,  // 5
      7'b1011111,  // 6
      7'b1110000,  // 7
      7'b1111111,  // 8
      7'b1111011,  // 9
      7'b1110111,  // A
      7'b0011111,  // b
      7'b1001110,  // C
      7'b0111101,  // d
      7'b1001111,  // E
      7'b1000111   // F
   };

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] din;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blank;
   } frame_t;

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Load handshake and display outputs of the scan driver, grouped for port use.
interface sseg_scan_driver_if;
   logic [15:0] din;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        load;
   logic        ready;
   logic [7:0]  sseg;
   logic [3:0]  anode;

   modport master (
      output din, dp_in, blank_in, load,
      input  ready, sseg, anode
   );

   modport slave (
      input  din, dp_in, blank_in, load,
      output ready, sseg, anode
   );
endinterface

// File: rtl/sseg_hex_decode.sv
// Combinational hex code to seven-segment glyph lookup.
module sseg_hex_decode
   import sseg_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   assign seg = GLYPH_ROM[code];

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with a one-deep pending buffer
// that is promoted to the display only at frame boundaries.
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int DIV = 50000
) (
   input  logic                     clk,
   input  logic                     rst,
   sseg_scan_driver_if.slave        bus
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0]      div_q, div_d;
   logic [1:0]            idx_q, idx_d;
   frame_t                pend_q, pend_d;
   logic                  pend_full_q, pend_full_d;
   frame_t                disp_q, disp_d;
   logic [7:0]            sseg_q, sseg_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;

   logic   tick;
   logic   frame_bnd;
   logic   accept;
   frame_t incoming;
   logic [3:0] cur_code;
   logic [6:0] cur_glyph;

   sseg_hex_decode u_dec (
      .code (cur_code),
      .seg  (cur_glyph)
   );

   always_comb begin
      tick      = (div_q == CNT_W'(DIV - 1));
      frame_bnd = tick && (idx_q == 2'd0);
      accept    = bus.load && !pend_full_q;
      incoming  = '{din: bus.din, dp: bus.dp_in, blank: bus.blank_in};

      div_d = tick ? '0 : div_q + 1'b1;
      idx_d = tick ? idx_q - 1'b1 : idx_q;

      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      disp_d      = disp_q;
      // A load landing on the boundary itself skips the buffer entirely.
      if (frame_bnd) begin
         if (pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
         end else if (accept) begin
            disp_d = incoming;
         end
      end else if (accept) begin
         pend_d      = incoming;
         pend_full_d = 1'b1;
      end

      cur_code = disp_q.din[{idx_q, 2'b00} +: 4];
      anode_d  = NUM_DIGITS'(1) << idx_q;
      sseg_d   = '0;
      if (!disp_q.blank[idx_q]) begin
         sseg_d[SEG_A:SEG_G] = cur_glyph;
         sseg_d[SEG_DP]      = disp_q.dp[idx_q];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q       <= '0;
         idx_q       <= 2'd3;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         disp_q      <= '0;
         sseg_q      <= '0;
         anode_q     <= '0;
      end else begin
         div_q       <= div_d;
         idx_q       <= idx_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         disp_q      <= disp_d;
         sseg_q      <= sseg_d;
         anode_q     <= anode_d;
      end
   end

   assign bus.ready = !pend_full_q;
   assign bus.sseg  = sseg_q;
   assign bus.anode = anode_q;

endmodule

// File: doc/sseg_scan_driver.md
SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 Parameter DIV, default 50000: clk cycles each digit stays lit; legal range 2..2^20.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 din  input  16  four hex codes; din[15:12]=digit 3 (leftmost) ... din[3:0]=digit 0.
REQ-005 dp_in  input  4  decimal point per digit, bit n = digit n, 1=lit.
REQ-006 blank_in  input  4  per-digit blank, bit n = digit n, 1=dark.
REQ-007 load  input  1  request to take din/dp_in/blank_in; accepted only when ready=1.
REQ-008 ready  output  1  high when the pending buffer is empty and a new load is accepted.
REQ-009 sseg  output  8  segments, active-high; bit7=a, bit6=b ... bit1=g, bit0=dp.
REQ-010 anode  output  4  digit enable, one-hot, active-high; anode[3]=leftmost digit.

Function
REQ-011 A divider counter shall count 0..DIV-1 and wrap; its wrap cycle is a "tick".
REQ-012 A 2-bit digit index shall start at 3 and decrement on each tick, wrapping 0->3.
REQ-013 The "frame boundary" shall be the tick on which the index moves from 0 to 3.
REQ-014 sseg and anode shall be registered: one cycle of latency from index/display-register state.
REQ-015 anode shall be the one-hot of the index; sseg[7:1] shall be the hex glyph (0-9, A, b, C, d, E, F) of the indexed code; sseg[0] shall be the indexed dp bit.
REQ-016 For a blanked digit, anode shall still be one-hot and sseg shall be 8'h00, dp included.
REQ-017 Glyphs: C=1001110, E=1001111, 0=1111110, 8=1111111, 1=0110000; the other codes shall follow the standard hex font.
REQ-018 load with ready=1 shall capture din/dp_in/blank_in into a pending buffer, and ready shall fall on the next cycle.
REQ-019 load with ready=0 shall be ignored; the pending contents shall not change.
REQ-020 At the frame boundary, a full pending buffer shall be copied to the display register, and ready shall rise on the next cycle.
REQ-021 load with ready=1 on a frame-boundary cycle shall bypass: din goes straight to the display register and ready stays 1.
REQ-022 The display register shall change only at frame boundaries, so no frame ever shows mixed old and new digits.

Reset
REQ-023 Reset values: divider=0; index=3; display register, dp and blank=0; pending empty; ready=1; sseg=8'h00; anode=4'b0000.
REQ-024 Reset asserted mid-frame or mid-pending shall discard the pending data and return every output to its reset value immediately, with no clock edge needed.
REQ-025 In the first cycle after rst falls, the driver shall scan digit 3; anode=4'b1000 shall appear after that cycle's edge.

Structure
REQ-026 Shared package sseg_pkg shall hold the segment-bit positions, the 16-entry glyph constants and the digit-count constant 4.
REQ-027 Hex-to-glyph decoding shall be one combinational sub-module, sseg_hex_decode (4-bit code in, 7 bits out).
REQ-028 The top module shall contain only the divider, index, pending/display registers, handshake and output registers.

Verification (DIV=4)
REQ-029 Reset, then load=1 with din=16'hCE10, dp_in=0, blank_in=0 on the first frame boundary -> four frames of sseg 9C,9E,60,FC with anode 1000,0100,0010,0001, 4 cycles each.
REQ-030 Load 16'h1234 mid-frame -> ready=0 the next cycle; the current frame still shows the old data; the next frame shows 1,2,3,4; ready returns to 1 one cycle after the boundary.
REQ-031 Second load 16'hFFFF while ready=0 -> ignored; only 16'h1234 is ever displayed.
REQ-032 blank_in=4'b0101, dp_in=4'b1111, din=16'h8888 -> digits 2 and 0 give sseg=00 with their anode still lit; digits 3 and 1 give sseg=FF.
REQ-033 Assert rst during digit 1 with a load pending -> sseg=00, anode=0000 and ready=1 without a clock edge; after release the scan restarts at digit 3 showing 0 glyphs (FC).
REQ-034 Checker on every cycle after reset: anode is one-hot or zero, and the display register changes only on frame-boundary cycles.
